// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regfile_arbiter_pkg;

    localparam int unsigned ADDR_W         = 7;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned STARVE_MAX_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_ACK    = 3'd4
    } arb_state_e;

    // One side's view of the register-file ports
    typedef struct packed {
        logic [ADDR_W-1:0] rd_addr;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] din;
        logic              wr_en;
    } rf_port_t;

endpackage : regfile_arbiter_pkg

// File: rtl/regfile_arb_starve_cnt.sv
// Counts busy-core cycles a pending debug request has waited; flags the
// cycle in which the count reaches STARVE_MAX.
module regfile_arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_W'(STARVE_MAX))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // High when this cycle's increment would bring the count to STARVE_MAX
    assign expired = (r_cnt == CNT_W'(STARVE_MAX - 1));

endmodule : regfile_arb_starve_cnt

// File: rtl/regfile_arbiter.sv
// Shares the register-file ports between the core and one debug requester.
// Define REGFILE_ARB_STARVE_EN to stall the core after STARVE_MAX busy cycles.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] core_rd_addr,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_din,
    input  logic              core_wr_en,
    input  logic              core_busy,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_dout
);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_starve_max
        $error("regfile_arbiter: STARVE_MAX must be within 1..255");
    end

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             w_expired;
    logic [DATA_W-1:0] r_dbg_rdata;
    rf_port_t         w_core_port;
    rf_port_t         w_dbg_port;
    rf_port_t         w_mem_port;

`ifdef REGFILE_ARB_STARVE_EN
    logic w_cnt_inc;
    logic w_cnt_clr;

    assign w_cnt_inc = (r_state == ST_WAIT) && core_busy;
    assign w_cnt_clr = (w_state_nxt == ST_ACCESS);

    regfile_arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_cnt_inc),
        .clr    (w_cnt_clr),
        .expired(w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; WAIT yields on an idle core slot or on starvation
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dbg_req) begin
                    w_state_nxt = core_busy ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (!core_busy || w_expired) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_ACK;
            ST_ACK:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data lands in RESP, one cycle after the debug address went out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_rdata <= '0;
        end else if ((r_state == ST_RESP) && !dbg_we) begin
            r_dbg_rdata <= mem_dout;
        end
    end

    assign w_core_port = '{rd_addr: core_rd_addr, wr_addr: core_wr_addr,
                           din: core_din, wr_en: core_wr_en};
    assign w_dbg_port  = '{rd_addr: dbg_addr, wr_addr: dbg_addr,
                           din: dbg_wdata, wr_en: dbg_we};

    // Mux select comes from the state register only, so reset reverts it at once
    assign w_mem_port = (r_state == ST_ACCESS) ? w_dbg_port : w_core_port;

    assign mem_rd_addr = w_mem_port.rd_addr;
    assign mem_wr_addr = w_mem_port.wr_addr;
    assign mem_din     = w_mem_port.din;
    assign mem_wr_en   = w_mem_port.wr_en;
    assign core_stall  = (r_state == ST_ACCESS);
    assign dbg_ack     = (r_state == ST_ACK);
    assign dbg_rdata   = r_dbg_rdata;

endmodule : regfile_arbiter

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: vector table of debug transactions,
// ack-time scoreboard for read data, and a reset-during-ACCESS sequence.
module tb_regfile_arbiter;
    import regfile_arbiter_pkg::*;

    localparam int unsigned N = 8;
`ifdef REGFILE_ARB_STARVE_EN
    localparam int STARVE_ACC = N + 1;
`else
    localparam int STARVE_ACC = 21;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] core_rd_addr, core_wr_addr, dbg_addr;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [DATA_W-1:0] core_din, dbg_wdata, dbg_rdata, mem_din, mem_dout;
    logic              core_wr_en, core_busy, core_stall;
    logic              dbg_req, dbg_we, dbg_ack, mem_wr_en;

    regfile_arbiter #(.STARVE_MAX(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_rd_addr(core_rd_addr), .core_wr_addr(core_wr_addr),
        .core_din(core_din), .core_wr_en(core_wr_en), .core_busy(core_busy),
        .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
        .mem_din(mem_din), .mem_wr_en(mem_wr_en), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory manager model: registered read with same-cycle write bypass
    logic [DATA_W-1:0] mem [128];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_din;
        mem_dout <= (mem_wr_en && (mem_wr_addr == mem_rd_addr)) ? mem_din : mem[mem_rd_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the read data expected for that transaction
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dbg_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                check("ack_rdata", 32'(dbg_rdata), 32'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                busy;
        logic              cwe;
        logic [ADDR_W-1:0] cwaddr;
        logic [DATA_W-1:0] cdin;
        int                exp_access;
        int                exp_ack;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int access_c = -1;
        int ack_c    = -1;
        int stalls   = 0;
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
        core_busy = (v.busy > 0);
        core_wr_en = v.cwe; core_wr_addr = v.cwaddr; core_din = v.cdin;
        core_rd_addr = ADDR_W'($urandom);
        sb_q.push_back(v.exp_rdata);
        for (int cyc = 0; cyc < 60 && ack_c < 0; cyc++) begin
            @(negedge clk);
            if (core_stall) begin
                stalls++;
                if (access_c < 0) begin
                    access_c = cyc;
                    check($sformatf("v%0d_acc_wr_en", idx), 32'(mem_wr_en), 32'(v.we));
                    check($sformatf("v%0d_acc_wr_addr", idx), 32'(mem_wr_addr), 32'(v.addr));
                    check($sformatf("v%0d_acc_rd_addr", idx), 32'(mem_rd_addr), 32'(v.addr));
                    check($sformatf("v%0d_acc_din", idx), 32'(mem_din), 32'(v.wdata));
                end
            end else begin
                check($sformatf("v%0d_c%0d_pass_rd", idx, cyc), 32'(mem_rd_addr), 32'(core_rd_addr));
                check($sformatf("v%0d_c%0d_pass_we", idx, cyc), 32'(mem_wr_en), 32'(core_wr_en));
            end
            if (dbg_ack) ack_c = cyc;
            @(posedge clk); #1;
            core_wr_en = 1'b0;
            core_rd_addr = ADDR_W'($urandom);
            core_busy = (cyc + 1 < v.busy);
            if (ack_c >= 0) dbg_req = 1'b0;
        end
        dbg_req = 1'b0;
        core_busy = 1'b0;
        check($sformatf("v%0d_access_cycle", idx), 32'(access_c), 32'(v.exp_access));
        check($sformatf("v%0d_ack_cycle", idx), 32'(ack_c), 32'(v.exp_ack));
        check($sformatf("v%0d_stall_count", idx), 32'(stalls), 32'd1);
        if (ack_c < 0 && sb_q.size() > 0) void'(sb_q.pop_back());
        @(negedge clk);
        check($sformatf("v%0d_idle_stall", idx), 32'(core_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h1F] = 8'hC3;
        //           we    addr   wdata  busy cwe   cwaddr cdin   acc ack rdata
        vecs[0] = '{1'b1, 7'h12, 8'h5A, 0,  1'b0, 7'h00, 8'h00, 1, 3, 8'h00};
        vecs[1] = '{1'b0, 7'h1F, 8'h00, 0,  1'b0, 7'h00, 8'h00, 1, 3, 8'hC3};
        vecs[2] = '{1'b0, 7'h12, 8'h00, 0,  1'b0, 7'h00, 8'h00, 1, 3, 8'h5A};
        vecs[3] = '{1'b1, 7'h40, 8'hA5, 2,  1'b0, 7'h00, 8'h00, 3, 5, 8'h5A};
        vecs[4] = '{1'b0, 7'h40, 8'h00, 20, 1'b0, 7'h00, 8'h00, STARVE_ACC, STARVE_ACC + 2, 8'hA5};
        vecs[5] = '{1'b0, 7'h1F, 8'h00, 20, 1'b0, 7'h00, 8'h00, STARVE_ACC, STARVE_ACC + 2, 8'hC3};
        vecs[6] = '{1'b1, 7'h03, 8'hFF, 0,  1'b0, 7'h00, 8'h00, 1, 3, 8'hC3};
        vecs[7] = '{1'b0, 7'h20, 8'h00, 0,  1'b1, 7'h20, 8'h77, 1, 3, 8'h77};

        rst_n = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        core_busy = 1'b0; core_wr_en = 1'b0; core_wr_addr = 7'h11;
        core_din = 8'h22; core_rd_addr = 7'h55;
        #12;
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_rdata", 32'(dbg_rdata), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_pass_rd", 32'(mem_rd_addr), 32'h55);
        check("rst_pass_wa", 32'(mem_wr_addr), 32'h11);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset pulse during ACCESS of a debug write
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h03; dbg_wdata = 8'h11;
        @(posedge clk); #3;
        check("rstacc_wr_en_before", 32'(mem_wr_en), 32'd1);
        check("rstacc_stall_before", 32'(core_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstacc_wr_en_async", 32'(mem_wr_en), 32'd0);
        check("rstacc_stall_async", 32'(core_stall), 32'd0);
        check("rstacc_pass_wa", 32'(mem_wr_addr), 32'(core_wr_addr));
        dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rstacc_c%0d_ack", c), 32'(dbg_ack), 32'd0);
            check($sformatf("rstacc_c%0d_stall", c), 32'(core_stall), 32'd0);
            check($sformatf("rstacc_c%0d_rdata", c), 32'(dbg_rdata), 32'd0);
        end
        check("rstacc_mem_untouched", 32'(mem[7'h03]), 32'hFF);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_arbiter
